// File: rtl/instr_fetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction fetch stage of the shrv32 core.
//                Issues one word fetch at a time on a req/gnt/rvalid memory
//                port. The returned word is held in a single instruction
//                register with a valid/ready handshake. The held word is
//                split into the decode fields that the controller uses.
//                Branch/jump redirects reload the fetch PC. A response that
//                is already in flight when a redirect arrives is discarded.
//
//  Parameters  : RESET_PC  - first fetch address after reset (bits [1:0]=0)
//                NOP_INST  - instruction register contents after reset
//
//  Optional    : IFETCH_ILLEGAL_CHECK_EN
//                  defined   -> a valid word with inst[1:0] != 2'b11 raises
//                               o_inst_illegal, and the word and its fields
//                               read as NOP_INST (o_inst_pc is unchanged)
//                  undefined -> o_inst_illegal = 0, raw word passed through
//
//  Ports       : clk               clock, rising edge
//                rst_n             synchronous active-low reset
//                o_imem_req        fetch request
//                o_imem_addr       word-aligned fetch address
//                i_imem_gnt        request accepted this cycle
//                i_imem_rvalid     read data valid
//                i_imem_rdata      read data
//                i_redirect_valid  PC redirect from branch/jump resolution
//                i_redirect_pc     redirect target (bits [1:0] ignored)
//                o_inst_valid      instruction register holds a valid word
//                i_inst_ready      downstream consumes the word this cycle
//                o_inst            instruction word
//                o_inst_pc         PC of o_inst
//                o_opcode          inst[6:2]
//                o_funct3          inst[14:12]
//                o_funct7          inst[31:25]
//                o_rs1/o_rs2/o_rd  inst[19:15] / inst[24:20] / inst[11:7]
//                o_inst_illegal    illegal-encoding flag
//
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    // instruction memory port
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    // redirect from branch/jump resolution
    input  logic        i_redirect_valid,
    input  logic [31:0] i_redirect_pc,
    // instruction output
    output logic        o_inst_valid,
    input  logic        i_inst_ready,
    output logic [31:0] o_inst,
    output logic [31:0] o_inst_pc,
    output logic [4:0]  o_opcode,
    output logic [2:0]  o_funct3,
    output logic [6:0]  o_funct7,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic        o_inst_illegal
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_fetch_pc;
    logic        r_discard;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic        r_inst_valid;

    logic        w_slot_free;
    logic        w_req;
    logic        w_fire;
    logic        w_load;
    logic [31:0] w_redirect_pc;
    logic [31:0] w_inst_out;
    logic        w_illegal;

    // The register can accept a word next cycle if it is empty now or is
    // being consumed now. A request is raised only then, so that the single
    // outstanding response always lands in an empty register.
    assign w_slot_free = !r_inst_valid || i_inst_ready;

    // Gated with rst_n so no request escapes in a cycle where reset is
    // sampled, whatever state the FSM is in before that edge.
    assign w_req  = rst_n && (r_state == ST_REQ) && w_slot_free;
    assign w_fire = w_req && i_imem_gnt;

    // A response is written only when it belongs to the current fetch PC:
    // a stale response (discard set) or one that coincides with a redirect
    // is dropped.
    assign w_load = (r_state == ST_WAIT) && i_imem_rvalid &&
                    !r_discard && !i_redirect_valid;

    assign w_redirect_pc = {i_redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_fetch_pc   <= RESET_PC;
            r_discard    <= 1'b0;
            r_inst       <= NOP_INST;
            r_inst_pc    <= RESET_PC;
            r_inst_valid <= 1'b0;
        end else begin
            // Consumption; a load later in this block overrides it.
            if (r_inst_valid && i_inst_ready) begin
                r_inst_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    // One dead cycle after reset. Any rvalid here belongs to
                    // a request issued before reset and is ignored.
                    r_state <= ST_REQ;
                end

                ST_REQ: begin
                    if (w_fire) begin
                        r_state <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (i_imem_rvalid) begin
                        r_state   <= ST_REQ;
                        r_discard <= 1'b0;
                        if (w_load) begin
                            r_inst       <= i_imem_rdata;
                            r_inst_pc    <= r_fetch_pc;
                            r_inst_valid <= 1'b1;
                            r_fetch_pc   <= r_fetch_pc + 32'd4;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Redirect overrides the normal update of the fetch PC and the
            // instruction register.
            if (i_redirect_valid) begin
                r_inst_valid <= 1'b0;
                r_fetch_pc   <= w_redirect_pc;
                // The request to the old address has been accepted, or is
                // still pending. Its response must be thrown away. A
                // response arriving in this same cycle has already been
                // dropped by the WAIT branch above.
                if ((r_state == ST_REQ) && w_fire) begin
                    r_discard <= 1'b1;
                end
                if ((r_state == ST_WAIT) && !i_imem_rvalid) begin
                    r_discard <= 1'b1;
                end
            end
        end
    end

`ifdef IFETCH_ILLEGAL_CHECK_EN
    // Only 32-bit encodings are supported. A compressed or invalid word is
    // flagged, and a NOP is presented so that the decoder never sees it.
    assign w_illegal  = r_inst_valid && (r_inst[1:0] != 2'b11);
    assign w_inst_out = w_illegal ? NOP_INST : r_inst;
`else
    assign w_illegal  = 1'b0;
    assign w_inst_out = r_inst;
`endif

    assign o_imem_req     = w_req;
    assign o_imem_addr    = r_fetch_pc;
    assign o_inst_valid   = r_inst_valid;
    assign o_inst         = w_inst_out;
    assign o_inst_pc      = r_inst_pc;
    assign o_opcode       = w_inst_out[6:2];
    assign o_funct3       = w_inst_out[14:12];
    assign o_funct7       = w_inst_out[31:25];
    assign o_rs1          = w_inst_out[19:15];
    assign o_rs2          = w_inst_out[24:20];
    assign o_rd           = w_inst_out[11:7];
    assign o_inst_illegal = w_illegal;

endmodule
`default_nettype wire
